eka_mem_arbiter: RTL and testbench

- Shares one unified memory port between the core's instruction-fetch requester and its load/store requester.
- Enables multi-cycle and pipelined Eka variants that no longer assume ideal single-cycle split caches.
- Arbitrates with a valid/ready handshake and allows one outstanding memory transaction at a time.
- Routes each memory response back to the requester that issued it.

---
 rtl/eka_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_eka_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eka_mem_arbiter.sv
`default_nettype none
// eka_mem_arbiter: shares one memory port between fetch and load/store, one transaction in flight.
// Revision 1.0
module eka_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_FIRST   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [31:0]           if_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_wr,
  input  logic [31:0]           d_req_wdata,
  input  logic [3:0]            d_req_be,
  output logic                  d_rsp_valid,
  output logic [31:0]           d_rsp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_RSP   = 2'd2;
  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [3:0]            starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  if_rsp_valid_q, if_rsp_valid_d;
  logic [31:0]           if_rsp_data_q, if_rsp_data_d;
  logic                  d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0]           d_rsp_data_q, d_rsp_data_d;

  logic gnt_if, gnt_data;
  logic hs_if, hs_data;

  // Arbitration; only takes effect through the readies, which exist only in IDLE.
  always_comb begin
    gnt_if   = 1'b0;
    gnt_data = 1'b0;
    if (if_req_valid && d_req_valid) begin
      if (DATA_FIRST != 0) begin
        gnt_data = (starve_q != C_LIMIT);
      end else begin
        gnt_data = (last_grant_q == 1'b0);
      end
      gnt_if = !gnt_data;
    end else begin
      gnt_if   = if_req_valid;
      gnt_data = d_req_valid;
    end
  end

  assign hs_if   = if_req_valid & if_req_ready;
  assign hs_data = d_req_valid & d_req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hs_if || hs_data) state_d = S_REQ;
      S_REQ:   if (mem_req_ready)    state_d = S_RSP;
      S_RSP:   if (mem_rsp_valid)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Readies are gated by reset so nothing is accepted while it is held.
  always_comb begin
    if_req_ready  = 1'b0;
    d_req_ready   = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if_req_ready = gnt_if & reset;
        d_req_ready  = gnt_data & reset;
      end
      S_REQ:   mem_req_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    starve_d       = starve_q;
    addr_d         = addr_q;
    wr_d           = wr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    d_rsp_valid_d  = 1'b0;
    d_rsp_data_d   = d_rsp_data_q;

    if (hs_if) begin
      owner_d      = 1'b0;
      last_grant_d = 1'b0;
      starve_d     = 4'd0;
      addr_d       = if_req_addr;
      wr_d         = 1'b0;
      wdata_d      = 32'd0;
      be_d         = 4'b1111;
    end else if (hs_data) begin
      owner_d      = 1'b1;
      last_grant_d = 1'b1;
      if (if_req_valid && (starve_q < C_LIMIT)) starve_d = starve_q + 4'd1;
      addr_d       = d_req_addr;
      wr_d         = d_req_wr;
      wdata_d      = d_req_wdata;
      be_d         = d_req_be;
    end

    if ((state_q == S_RSP) && mem_rsp_valid) begin
      if (owner_q) begin
        d_rsp_valid_d = 1'b1;
        d_rsp_data_d  = wr_q ? 32'd0 : mem_rsp_data;
      end else begin
        if_rsp_valid_d = 1'b1;
        if_rsp_data_d  = mem_rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      starve_q       <= 4'd0;
      addr_q         <= '0;
      wr_q           <= 1'b0;
      wdata_q        <= 32'd0;
      be_q           <= 4'd0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= 32'd0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_data_q   <= 32'd0;
    end else begin
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      starve_q       <= starve_d;
      addr_q         <= addr_d;
      wr_q           <= wr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_data_q   <= d_rsp_data_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wr       = wr_q;
  assign mem_wdata    = wdata_q;
  assign mem_be       = be_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_data   = d_rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_eka_mem_arbiter.sv
`default_nettype none
// tb_eka_mem_arbiter: scoreboard bench for eka_mem_arbiter (priority and round-robin instances).
// Revision 1.0
module tb_eka_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = 32'd0;
  logic        d_req_valid = 1'b0;
  logic [31:0] d_req_addr = 32'd0;
  logic        d_req_wr = 1'b0;
  logic [31:0] d_req_wdata = 32'd0;
  logic [3:0]  d_req_be = 4'd0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'd0;

  logic        if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid, mem_req_valid, mem_wr;
  logic [31:0] if_rsp_data, d_rsp_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        rr_if_req_ready, rr_if_rsp_valid, rr_d_req_ready, rr_d_rsp_valid;
  logic        rr_mem_req_valid, rr_mem_wr;
  logic [31:0] rr_if_rsp_data, rr_d_rsp_data, rr_mem_addr, rr_mem_wdata;
  logic [3:0]  rr_mem_be;

  typedef struct {
    logic        is_data;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mon_data;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  eka_mem_arbiter #(.ADDR_WIDTH(32), .DATA_FIRST(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wr(d_req_wr), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  // Round-robin instance runs in lockstep on the same stimulus.
  eka_mem_arbiter #(.ADDR_WIDTH(32), .DATA_FIRST(0), .STARVE_LIMIT(4)) dut_rr (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(rr_if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(rr_if_rsp_valid), .if_rsp_data(rr_if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(rr_d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wr(d_req_wr), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(rr_d_rsp_valid), .d_rsp_data(rr_d_rsp_data),
    .mem_req_valid(rr_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(rr_mem_addr),
    .mem_wr(rr_mem_wr), .mem_wdata(rr_mem_wdata), .mem_be(rr_mem_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every pulse.
  always @(negedge clk) begin
    if (if_rsp_valid || d_rsp_valid) begin
      n_chk++;
      if (if_rsp_valid && d_rsp_valid) begin
        n_fail++;
        $display("FAIL rsp_both: got if=1 d=1, want a single owner pulse");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_spurious: got pulse (data owner=%0d) at cycle %0d, want none", d_rsp_valid, cyc);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_data = d_rsp_valid ? d_rsp_data : if_rsp_data;
        if (d_rsp_valid !== mon_e.is_data) begin
          n_fail++;
          $display("FAIL rsp_owner: got %0d, want %0d", d_rsp_valid, mon_e.is_data);
        end
        n_chk++;
        if (mon_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL rsp_data: got %h, want %h", mon_data, mon_e.data);
        end
        n_chk++;
        if (cyc != mon_e.due) begin
          n_fail++;
          $display("FAIL rsp_latency: got cycle %0d, want cycle %0d", cyc, mon_e.due);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({if_req_ready, d_req_ready, mem_req_valid, if_rsp_valid, d_rsp_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b, want 00000",
               {if_req_ready, d_req_ready, mem_req_valid, if_rsp_valid, d_rsp_valid});
    end
    n_chk++;
    if (mem_addr !== 32'd0 || mem_wr !== 1'b0 || mem_wdata !== 32'd0 || mem_be !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mem_fields: got %h %b %h %h, want all zero", mem_addr, mem_wr, mem_wdata, mem_be);
    end
    n_chk++;
    if (if_rsp_data !== 32'd0 || d_rsp_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rsp_data: got %h %h, want 0 0", if_rsp_data, d_rsp_data);
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fetch_only();
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h100;
    #1;
    n_chk++;
    if ({if_req_ready, d_req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL fetch_ready: got %b, want 10", {if_req_ready, d_req_ready});
    end
    exp_q.push_back('{is_data: 1'b0, data: 32'h00500093, due: cyc + 3});
    @(negedge clk);
    if_req_valid = 1'b0;
    #1;
    n_chk++;
    if ({mem_req_valid, mem_addr, mem_be, mem_wr} !== {1'b1, 32'h100, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_mem_req: got v=%b a=%h be=%h wr=%b, want v=1 a=00000100 be=f wr=0",
               mem_req_valid, mem_addr, mem_be, mem_wr);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h00500093;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fetch_pending: got %0d outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    d_req_valid = 1'b1;
    d_req_addr  = 32'h2000;
    d_req_wr    = 1'b1;
    d_req_wdata = 32'hDEADBEEF;
    d_req_be    = 4'b0011;
    #1;
    n_chk++;
    if ({if_req_ready, d_req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL store_ready: got %b, want 01", {if_req_ready, d_req_ready});
    end
    exp_q.push_back('{is_data: 1'b1, data: 32'd0, due: cyc + 3});
    @(negedge clk);
    d_req_valid = 1'b0;
    d_req_wr    = 1'b0;
    d_req_wdata = 32'd0;
    #1;
    n_chk++;
    if ({mem_req_valid, mem_addr, mem_wr, mem_wdata, mem_be} !== {1'b1, 32'h2000, 1'b1, 32'hDEADBEEF, 4'b0011}) begin
      n_fail++;
      $display("FAIL store_mem_req: got v=%b a=%h wr=%b wd=%h be=%b, want v=1 a=00002000 wr=1 wd=deadbeef be=0011",
               mem_req_valid, mem_addr, mem_wr, mem_wdata, mem_be);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h12345678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL store_pending: got %0d outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    d_req_valid = 1'b1;
    d_req_addr  = 32'h3000;
    d_req_wr    = 1'b0;
    d_req_be    = 4'b1100;
    #1;
    exp_q.push_back('{is_data: 1'b1, data: 32'hCAFEF00D, due: cyc + 8});
    @(negedge clk);
    d_req_valid  = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h180;
    for (int s = 0; s < 5; s++) begin
      #1;
      n_chk++;
      if ({mem_req_valid, mem_addr, mem_wr, mem_be, if_req_ready, d_req_ready, d_rsp_valid}
          !== {1'b1, 32'h3000, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b a=%h wr=%b be=%b rdy=%b%b drsp=%b, want v=1 a=00003000 wr=0 be=1100 rdy=00 drsp=0",
                 s, mem_req_valid, mem_addr, mem_wr, mem_be, if_req_ready, d_req_ready, d_rsp_valid);
      end
      mem_rsp_valid = (s == 2);
      mem_rsp_data  = 32'hBADBAD00;
      @(negedge clk);
    end
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFEF00D;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_pending: got %0d outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_rsp();
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h400;
    @(negedge clk);
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2;
    reset        = 1'b0;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    #1;
    n_chk++;
    if ({if_req_ready, d_req_ready, mem_req_valid, if_rsp_valid, d_rsp_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b, want 00000",
               {if_req_ready, d_req_ready, mem_req_valid, if_rsp_valid, d_rsp_valid});
    end
    @(negedge clk);
    reset         = 1'b1;
    if_req_valid  = 1'b0;
    d_req_valid   = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0BAD0BAD;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    n_chk++;
    if ({if_rsp_valid, d_rsp_valid, mem_req_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL late_rsp_ignored: got %b, want 000", {if_rsp_valid, d_rsp_valid, mem_req_valid});
    end
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h500;
    #1;
    n_chk++;
    if (if_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %b, want 1", if_req_ready);
    end
    exp_q.push_back('{is_data: 1'b0, data: 32'h11111111, due: cyc + 3});
    @(negedge clk);
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h11111111;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_pending: got %0d outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_contention();
    logic [3:0] cnt;
    logic       exp_data_win;
    logic       exp_rr_data;
    cnt = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h600;
    d_req_valid  = 1'b1;
    d_req_addr   = 32'h700;
    d_req_wr     = 1'b0;
    d_req_be     = 4'hF;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_data_win = (cnt != 4'd4);
      exp_rr_data  = (i % 2) == 1;
      n_chk++;
      if ({if_req_ready, d_req_ready} !== {!exp_data_win, exp_data_win}) begin
        n_fail++;
        $display("FAIL prio_grant[%0d]: got %b, want %b", i, {if_req_ready, d_req_ready}, {!exp_data_win, exp_data_win});
      end
      n_chk++;
      if ({rr_if_req_ready, rr_d_req_ready} !== {!exp_rr_data, exp_rr_data}) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b, want %b", i, {rr_if_req_ready, rr_d_req_ready}, {!exp_rr_data, exp_rr_data});
      end
      cnt = exp_data_win ? cnt + 4'd1 : 4'd0;
      exp_q.push_back('{is_data: exp_data_win, data: 32'hA000 + 32'(i), due: cyc + 3});
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hA000 + 32'(i);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL contention_pending: got %0d outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch_only();
    test_store();
    test_backpressure();
    test_reset_mid_rsp();
    test_contention();
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_pending: got %0d outstanding, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
